sram_port_arbiter: RTL and testbench



---
 rtl/sram_arb_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/sram_port_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared widths, command encodings and pipeline slot types for the SRAM port arbiter
package sram_arb_pkg;

    localparam int ADDR_W_DEF        = 18;
    localparam int DATA_W_DEF        = 32;
    localparam int N_RD_DEF          = 2;
    localparam int RD_LAT_DEF        = 2;
    localparam int WR_STREAK_MAX_DEF = 8;

    // Command issued to the SRAM in the cycle after a grant
    localparam logic [1:0] CMD_IDLE = 2'd0;
    localparam logic [1:0] CMD_RD   = 2'd1;
    localparam logic [1:0] CMD_WR   = 2'd2;

    // Control bits that travel with every data-pipeline slot
    typedef struct packed {
        logic valid;
        logic is_write;
    } slot_hdr_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot arbiter, search starts one past the last winner
module rr_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] last,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             any
);

    // Walk priorities last+1, last+2, ... with wrap; first requester found wins
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int k = 1; k <= N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!any && req[i] && (i == (int'(last) + k) % N)) begin
                    any       = 1'b1;
                    grant[i]  = 1'b1;
                    grant_idx = PTR_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - one write and N_RD read channels arbitrated onto a pipelined ZBT SRAM port
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int N_RD          = N_RD_DEF,
    parameter int RD_LAT        = RD_LAT_DEF,
    parameter int WR_STREAK_MAX = WR_STREAK_MAX_DEF
) (
    input  logic                   clk_100,
    input  logic                   rst,

    input  logic                   wr_req,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic [DATA_W/8-1:0]    wr_be,
    output logic                   wr_ack,

    input  logic [N_RD-1:0]        rd_req,
    input  logic [N_RD*ADDR_W-1:0] rd_addr,
    output logic [N_RD-1:0]        rd_ack,
    output logic [N_RD-1:0]        rd_valid,
    output logic [DATA_W-1:0]      rd_data,

    output logic [ADDR_W-1:0]      address_to_sram,
    output logic                   chip_en_n,
    output logic                   write_en_n,
    output logic                   output_en_n,
    output logic [DATA_W/8-1:0]    byte_en_n,
    output logic                   adv,
    input  logic [DATA_W-1:0]      sram_dq_i,
    output logic [DATA_W-1:0]      sram_dq_o,
    output logic                   sram_dq_oe
);

    localparam int BE_W     = DATA_W / 8;
    localparam int CH_W     = (N_RD > 1) ? $clog2(N_RD) : 1;
    localparam int STREAK_W = $clog2(WR_STREAK_MAX + 1);

    typedef struct packed {
        slot_hdr_t         hdr;
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] data;
    } slot_t;

    logic                rd_pending;
    logic [STREAK_W-1:0] streak;
    logic [CH_W-1:0]     last_rd;
    logic [N_RD-1:0]     rr_grant;
    logic [CH_W-1:0]     rr_idx;
    logic                rr_any;
    logic                grant_wr;
    logic                grant_rd;
    logic [1:0]          cmd;
    logic [ADDR_W-1:0]   sel_rd_addr;
    slot_t               slot_in;
    slot_t               pipe [RD_LAT];
    logic                cap_valid;
    logic [CH_W-1:0]     cap_ch;

    assign rd_pending = |rd_req;
    assign adv        = 1'b0;

    rr_arbiter #(
        .N     (N_RD),
        .PTR_W (CH_W)
    ) u_rr (
        .req       (rd_req),
        .last      (last_rd),
        .grant     (rr_grant),
        .grant_idx (rr_idx),
        .any       (rr_any)
    );

    // Writes win unless reads are waiting and the write streak has hit its bound
    assign grant_wr = wr_req && (!rd_pending || (streak < STREAK_W'(WR_STREAK_MAX)));
    assign grant_rd = !grant_wr && rr_any;
    assign wr_ack   = grant_wr;
    assign rd_ack   = grant_rd ? rr_grant : '0;
    assign cmd      = grant_wr ? CMD_WR : (grant_rd ? CMD_RD : CMD_IDLE);

    // Address of the winning read channel
    always_comb begin
        sel_rd_addr = '0;
        for (int c = 0; c < N_RD; c++) begin
            if (rr_grant[c]) begin
                sel_rd_addr = rd_addr[c*ADDR_W +: ADDR_W];
            end
        end
    end

    // Write streak bound and round-robin pointer
    always_ff @(posedge clk_100 or negedge rst) begin
        if (!rst) begin
            streak  <= '0;
            last_rd <= CH_W'(N_RD - 1);
        end else begin
            if (grant_rd || !rd_pending) begin
                streak <= '0;
            end else if (grant_wr && (streak < STREAK_W'(WR_STREAK_MAX))) begin
                streak <= streak + STREAK_W'(1);
            end
            if (grant_rd) begin
                last_rd <= rr_idx;
            end
        end
    end

    // Registered SRAM command one cycle after the grant
    always_ff @(posedge clk_100 or negedge rst) begin
        if (!rst) begin
            address_to_sram <= '0;
            chip_en_n       <= 1'b1;
            write_en_n      <= 1'b1;
            output_en_n     <= 1'b1;
            byte_en_n       <= '1;
        end else begin
            case (cmd)
                CMD_WR: begin
                    address_to_sram <= wr_addr;
                    chip_en_n       <= 1'b0;
                    write_en_n      <= 1'b0;
                    output_en_n     <= 1'b1;
                    byte_en_n       <= ~wr_be;
                end
                CMD_RD: begin
                    address_to_sram <= sel_rd_addr;
                    chip_en_n       <= 1'b0;
                    write_en_n      <= 1'b1;
                    output_en_n     <= 1'b0;
                    byte_en_n       <= {BE_W{1'b0}};
                end
                default: begin
                    chip_en_n       <= 1'b1;
                    write_en_n      <= 1'b1;
                    output_en_n     <= 1'b1;
                    byte_en_n       <= {BE_W{1'b1}};
                end
            endcase
        end
    end

    // Slot entering the data pipeline alongside the command
    always_comb begin
        slot_in              = '0;
        slot_in.hdr.valid    = (cmd != CMD_IDLE);
        slot_in.hdr.is_write = (cmd == CMD_WR);
        slot_in.ch           = rr_idx;
        slot_in.data         = wr_data;
    end

    // Data pipeline: slot k is visible k+1 cycles after the grant
    always_ff @(posedge clk_100 or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= slot_in;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Data-phase stage: drive write data or arm read capture at grant+1+RD_LAT
    always_ff @(posedge clk_100 or negedge rst) begin
        if (!rst) begin
            sram_dq_oe <= 1'b0;
            sram_dq_o  <= '0;
            cap_valid  <= 1'b0;
            cap_ch     <= '0;
        end else begin
            sram_dq_oe <= pipe[RD_LAT-1].hdr.valid && pipe[RD_LAT-1].hdr.is_write;
            if (pipe[RD_LAT-1].hdr.valid && pipe[RD_LAT-1].hdr.is_write) begin
                sram_dq_o <= pipe[RD_LAT-1].data;
            end
            cap_valid  <= pipe[RD_LAT-1].hdr.valid && !pipe[RD_LAT-1].hdr.is_write;
            cap_ch     <= pipe[RD_LAT-1].ch;
        end
    end

    // Capture read data from the pad and tag it to its channel
    always_ff @(posedge clk_100 or negedge rst) begin
        if (!rst) begin
            rd_data  <= '0;
            rd_valid <= '0;
        end else begin
            if (cap_valid) begin
                rd_data <= sram_dq_i;
            end
            for (int c = 0; c < N_RD; c++) begin
                rd_valid[c] <= cap_valid && (cap_ch == CH_W'(c));
            end
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - randomized and directed bench for sram_port_arbiter with a reference model
module tb_sram_port_arbiter;

    localparam int ADDR_W        = 18;
    localparam int DATA_W        = 32;
    localparam int N_RD          = 3;
    localparam int RD_LAT        = 2;
    localparam int WR_STREAK_MAX = 8;
    localparam int BE_W          = DATA_W / 8;
    localparam int MEM_N         = 64;
    localparam int RING          = 16;

    logic                   clk_100 = 1'b0;
    logic                   rst;
    logic                   wr_req;
    logic [ADDR_W-1:0]      wr_addr;
    logic [DATA_W-1:0]      wr_data;
    logic [BE_W-1:0]        wr_be;
    logic                   wr_ack;
    logic [N_RD-1:0]        rd_req;
    logic [N_RD*ADDR_W-1:0] rd_addr;
    logic [N_RD-1:0]        rd_ack;
    logic [N_RD-1:0]        rd_valid;
    logic [DATA_W-1:0]      rd_data;
    logic [ADDR_W-1:0]      address_to_sram;
    logic                   chip_en_n;
    logic                   write_en_n;
    logic                   output_en_n;
    logic [BE_W-1:0]        byte_en_n;
    logic                   adv;
    logic [DATA_W-1:0]      sram_dq_i;
    logic [DATA_W-1:0]      sram_dq_o;
    logic                   sram_dq_oe;

    always #5 clk_100 = ~clk_100;

    sram_port_arbiter #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .N_RD          (N_RD),
        .RD_LAT        (RD_LAT),
        .WR_STREAK_MAX (WR_STREAK_MAX)
    ) dut (
        .clk_100         (clk_100),
        .rst             (rst),
        .wr_req          (wr_req),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .wr_be           (wr_be),
        .wr_ack          (wr_ack),
        .rd_req          (rd_req),
        .rd_addr         (rd_addr),
        .rd_ack          (rd_ack),
        .rd_valid        (rd_valid),
        .rd_data         (rd_data),
        .address_to_sram (address_to_sram),
        .chip_en_n       (chip_en_n),
        .write_en_n      (write_en_n),
        .output_en_n     (output_en_n),
        .byte_en_n       (byte_en_n),
        .adv             (adv),
        .sram_dq_i       (sram_dq_i),
        .sram_dq_o       (sram_dq_o),
        .sram_dq_oe      (sram_dq_oe)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [DATA_W-1:0] ref_mem [MEM_N];
    logic [DATA_W-1:0] dev_mem [MEM_N];
    int                m_streak;
    int                m_last;
    int                pk_kind;
    logic [BE_W-1:0]   pk_be;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_rd_data;
    bit                ws_v  [RING];
    logic [DATA_W-1:0] ws_d  [RING];
    bit                rv_v  [RING];
    int                rv_ch [RING];
    logic [DATA_W-1:0] rv_d  [RING];
    int                dv_kind [RING];
    logic [ADDR_W-1:0] dv_addr [RING];
    logic [BE_W-1:0]   dv_be   [RING];
    bit                g_wr;
    int                g_rd;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                                input logic [DATA_W-1:0] nw,
                                                input logic [BE_W-1:0] be);
        logic [DATA_W-1:0] r;
        r = old;
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        end
        return r;
    endfunction

    task automatic model_reset();
        m_streak    = 0;
        m_last      = N_RD - 1;
        pk_kind     = 0;
        pk_be       = '0;
        exp_addr    = '0;
        exp_rd_data = '0;
        g_wr        = 1'b0;
        g_rd        = -1;
        for (int i = 0; i < RING; i++) begin
            ws_v[i]    = 1'b0;
            rv_v[i]    = 1'b0;
            dv_kind[i] = 0;
        end
    endtask

    task automatic clear_reqs();
        wr_req = 1'b0;
        rd_req = '0;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_acks"}, {wr_ack, rd_ack, rd_valid, sram_dq_oe, adv}, 64'd0);
        check_eq({tag, "_rd_data"}, rd_data, 64'd0);
        check_eq({tag, "_dq_o"}, sram_dq_o, 64'd0);
        check_eq({tag, "_addr"}, address_to_sram, 64'd0);
        check_eq({tag, "_ctl"}, {chip_en_n, write_en_n, output_en_n, byte_en_n}, {3'b111, {BE_W{1'b1}}});
    endtask

    // Opens a cycle: after the edge, the SRAM device drives read data due now
    task automatic cycle_start();
        int s;
        @(posedge clk_100);
        #1;
        cyc++;
        s = cyc % RING;
        if (dv_kind[s] == 1) sram_dq_i = dev_mem[dv_addr[s][5:0]];
        else                 sram_dq_i = $urandom;
    endtask

    // Closes a cycle: compare against the model, run the device, advance the model
    task automatic cycle_end();
        int                s;
        int                d;
        bit                rd_pend;
        logic [N_RD-1:0]   exp_ack;
        logic [N_RD-1:0]   exp_valid;
        logic [BE_W-1:0]   exp_be;
        logic [ADDR_W-1:0] a;
        @(negedge clk_100);
        s       = cyc % RING;
        rd_pend = (rd_req != '0);
        g_wr    = wr_req && (!rd_pend || m_streak < WR_STREAK_MAX);
        g_rd    = -1;
        if (!g_wr && rd_pend) begin
            for (int k = 1; k <= N_RD; k++) begin
                if (g_rd < 0 && ((rd_req >> ((m_last + k) % N_RD)) & 1) != 0) g_rd = (m_last + k) % N_RD;
            end
        end
        exp_ack = '0;
        if (g_rd >= 0) exp_ack = N_RD'(1) << g_rd;
        check_eq("wr_ack", wr_ack, g_wr);
        check_eq("rd_ack", rd_ack, exp_ack);

        if (pk_kind == 2)      exp_be = ~pk_be;
        else if (pk_kind == 1) exp_be = {BE_W{1'b0}};
        else                   exp_be = {BE_W{1'b1}};
        check_eq("chip_en_n", chip_en_n, pk_kind == 0);
        check_eq("write_en_n", write_en_n, pk_kind != 2);
        check_eq("output_en_n", output_en_n, pk_kind != 1);
        check_eq("byte_en_n", byte_en_n, exp_be);
        check_eq("address_to_sram", address_to_sram, exp_addr);
        check_eq("adv", adv, 1'b0);

        check_eq("sram_dq_oe", sram_dq_oe, ws_v[s]);
        if (ws_v[s]) check_eq("sram_dq_o", sram_dq_o, ws_d[s]);
        exp_valid = '0;
        if (rv_v[s]) begin
            exp_valid   = N_RD'(1) << rv_ch[s];
            exp_rd_data = rv_d[s];
        end
        check_eq("rd_valid", rd_valid, exp_valid);
        check_eq("rd_data", rd_data, exp_rd_data);
        ws_v[s] = 1'b0;
        rv_v[s] = 1'b0;

        if (dv_kind[s] == 2) dev_mem[dv_addr[s][5:0]] = merge(dev_mem[dv_addr[s][5:0]], sram_dq_o, dv_be[s]);
        dv_kind[s] = 0;
        if (!chip_en_n) begin
            d          = (cyc + RD_LAT) % RING;
            dv_kind[d] = write_en_n ? 1 : 2;
            dv_addr[d] = address_to_sram;
            dv_be[d]   = ~byte_en_n;
        end

        if (g_rd >= 0 || !rd_pend) m_streak = 0;
        else if (g_wr && m_streak < WR_STREAK_MAX) m_streak++;
        if (g_wr) begin
            ref_mem[wr_addr[5:0]] = merge(ref_mem[wr_addr[5:0]], wr_data, wr_be);
            d       = (cyc + 1 + RD_LAT) % RING;
            ws_v[d] = 1'b1;
            ws_d[d] = wr_data;
            pk_kind  = 2;
            pk_be    = wr_be;
            exp_addr = wr_addr;
        end else if (g_rd >= 0) begin
            a        = rd_addr[g_rd*ADDR_W +: ADDR_W];
            d        = (cyc + 2 + RD_LAT) % RING;
            rv_v[d]  = 1'b1;
            rv_ch[d] = g_rd;
            rv_d[d]  = ref_mem[a[5:0]];
            pk_kind  = 1;
            exp_addr = a;
            m_last   = g_rd;
        end else begin
            pk_kind = 0;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            cycle_start();
            clear_reqs();
            cycle_end();
        end
    endtask

    initial begin
        int nw;
        int lat;
        int rd_i;
        bit seen_rd;
        bit resumed;

        rst       = 1'b0;
        wr_req    = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        wr_be     = '0;
        rd_req    = '0;
        rd_addr   = '0;
        sram_dq_i = '0;
        for (int i = 0; i < MEM_N; i++) begin
            ref_mem[i] = 32'hA500_0000 | DATA_W'(i);
            dev_mem[i] = 32'hA500_0000 | DATA_W'(i);
        end
        model_reset();

        repeat (3) @(negedge clk_100);
        check_reset_vals("reset");
        rst = 1'b1;

        // Round-robin from reset: all channels continuously requesting
        for (int k = 0; k < 6; k++) begin
            cycle_start();
            clear_reqs();
            rd_req = '1;
            for (int c = 0; c < N_RD; c++) rd_addr[c*ADDR_W +: ADDR_W] = ADDR_W'(30 + 3*c + k);
            cycle_end();
            check_eq("rr_order", rd_ack, N_RD'(1) << (k % N_RD));
        end
        idle_cycles(5);

        // Single write then read back on channel 0
        cycle_start();
        wr_req = 1'b1; wr_addr = 18'h00010; wr_data = 32'h1234_5678; wr_be = 4'hF;
        cycle_end();
        cycle_start();
        clear_reqs();
        rd_req = 3'b001; rd_addr[0 +: ADDR_W] = 18'h00010;
        cycle_end();
        lat = 0;
        for (int i = 1; i <= 6; i++) begin
            cycle_start();
            clear_reqs();
            cycle_end();
            if (rd_valid[0] && lat == 0) lat = i;
        end
        check_eq("rd_latency", lat, 4);
        check_eq("wr_then_rd_data", rd_data, 32'h1234_5678);

        // Partial byte-enable write and readback
        cycle_start();
        wr_req = 1'b1; wr_addr = 18'h00011; wr_data = 32'hAABB_CCDD; wr_be = 4'b0101;
        cycle_end();
        cycle_start();
        clear_reqs();
        cycle_end();
        check_eq("be_cmd", byte_en_n, 4'b1010);
        cycle_start();
        rd_req = 3'b100; rd_addr[2*ADDR_W +: ADDR_W] = 18'h00011;
        cycle_end();
        idle_cycles(6);
        check_eq("be_readback", rd_data, 32'hA5BB_00DD);

        // Starvation bound with write and read 1 held
        nw = 0; seen_rd = 1'b0; resumed = 1'b0; rd_i = -10;
        for (int i = 0; i < 12; i++) begin
            cycle_start();
            wr_req = 1'b1; wr_addr = ADDR_W'(20 + i); wr_data = $urandom; wr_be = '1;
            rd_req = seen_rd ? 3'b000 : 3'b010;
            rd_addr[ADDR_W +: ADDR_W] = 18'd7;
            cycle_end();
            if (!seen_rd) begin
                if (rd_ack == 3'b010) begin
                    seen_rd = 1'b1;
                    rd_i    = i;
                end else if (wr_ack) begin
                    nw++;
                end
            end else if (i == rd_i + 1) begin
                resumed = wr_ack;
            end
        end
        check_eq("starve_writes_first", nw, 8);
        check_eq("starve_read_seen", seen_rd, 1'b1);
        check_eq("starve_write_resumes", resumed, 1'b1);
        idle_cycles(6);

        // Interleaved read / write every cycle
        for (int i = 0; i < 12; i++) begin
            cycle_start();
            clear_reqs();
            if (i % 2 == 0) begin
                rd_req = N_RD'(1) << ((i / 2) % N_RD);
                rd_addr[((i / 2) % N_RD)*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(15));
            end else begin
                wr_req = 1'b1; wr_addr = ADDR_W'($urandom_range(15)); wr_data = $urandom; wr_be = $urandom;
            end
            cycle_end();
        end
        idle_cycles(6);

        // Randomized traffic with held requests and occasional withdrawal
        for (int i = 0; i < 2000; i++) begin
            cycle_start();
            if (!wr_req || g_wr) begin
                wr_req  = ($urandom_range(99) < 45);
                wr_addr = ADDR_W'($urandom_range(MEM_N - 1));
                wr_data = $urandom;
                wr_be   = $urandom;
            end else if ($urandom_range(99) < 3) begin
                wr_req = 1'b0;
            end
            for (int c = 0; c < N_RD; c++) begin
                if (!rd_req[c] || g_rd == c) begin
                    rd_req[c] = ($urandom_range(99) < 30);
                    rd_addr[c*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(MEM_N - 1));
                end else if ($urandom_range(99) < 3) begin
                    rd_req[c] = 1'b0;
                end
            end
            cycle_end();
        end
        idle_cycles(6);

        // Reset with two reads in flight
        cycle_start();
        clear_reqs();
        rd_req = 3'b001; rd_addr[0 +: ADDR_W] = 18'd3;
        cycle_end();
        cycle_start();
        clear_reqs();
        rd_req = 3'b010; rd_addr[ADDR_W +: ADDR_W] = 18'd5;
        cycle_end();
        clear_reqs();
        rst = 1'b0;
        #1;
        check_reset_vals("rst_mid_a");
        @(negedge clk_100);
        check_reset_vals("rst_mid_b");
        @(negedge clk_100);
        rst = 1'b1;
        model_reset();
        idle_cycles(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
